if_redirect_unit: RTL and testbench

- Fetch-side partner of the execute stage. It owns the program counter and the IF/ID pipeline register.
- It consumes the redirect request and target address that the execute stage produces (jump, branch or register jump) and squashes the younger instructions in flight.
- It applies the load-use stall from the hazard unit.
- It keeps a sticky misaligned-target error and saturating fetch/redirect performance counters.

---
 rtl/if_redirect_unit.sv | 118 +++++++++++
 tb/tb_if_redirect_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_redirect_unit: PC and IF/ID owner; applies EX redirects, stalls    |
// | and misaligned-target halting.                     Revision: 1.0      |
// +----------------------------------------------------------------------+
module if_redirect_unit #(
   parameter int unsigned      NBits          = 32,
   parameter logic [NBits-1:0] ResetPC        = NBits'(32'h0040_0000),
   parameter bit               HaltOnMisalign = 1'b1,
   parameter int unsigned      CntBits        = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               Stall,
   input  logic               Redirect,
   input  logic [NBits-1:0]   RedirectPC,
   input  logic [NBits-1:0]   Instruction,
   output logic [NBits-1:0]   PC,
   output logic [NBits-1:0]   IF_ID_PC_4,
   output logic [NBits-1:0]   IF_ID_Instruction,
   output logic               IF_ID_Valid,
   output logic               FlushIDEX,
   output logic               AddrError,
   output logic               Halted,
   output logic [CntBits-1:0] FetchCount,
   output logic [CntBits-1:0] RedirectCount
);

   localparam logic [NBits-1:0]   c_pcStep = NBits'(4);
   localparam logic [CntBits-1:0] c_cntOne = CntBits'(1);
   localparam logic [CntBits-1:0] c_cntMax = '1;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   state_t             r_state;
   logic [NBits-1:0]   r_pc;
   logic [NBits-1:0]   r_ifIdPc4;
   logic [NBits-1:0]   r_ifIdInst;
   logic               r_ifIdValid;
   logic               r_addrError;
   logic               r_halted;
   logic [CntBits-1:0] r_fetchCount;
   logic [CntBits-1:0] r_redirectCount;

   logic               w_misaligned;
   logic [NBits-1:0]   w_pcPlus4;
   logic [NBits-1:0]   w_redirTarget;

   assign w_misaligned  = |RedirectPC[1:0];
   assign w_pcPlus4     = r_pc + c_pcStep;
   assign w_redirTarget = {RedirectPC[NBits-1:2], 2'b00};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state         <= S_RUN;
         r_pc            <= ResetPC;
         r_ifIdPc4       <= '0;
         r_ifIdInst      <= '0;
         r_ifIdValid     <= 1'b0;
         r_addrError     <= 1'b0;
         r_halted        <= 1'b0;
         r_fetchCount    <= '0;
         r_redirectCount <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (Redirect) begin
                  // Squash IF/ID; a pending stall is moot since that instruction dies.
                  r_ifIdPc4   <= '0;
                  r_ifIdInst  <= '0;
                  r_ifIdValid <= 1'b0;
                  if (w_misaligned)
                     r_addrError <= 1'b1;
                  if (w_misaligned && HaltOnMisalign) begin
                     r_state  <= S_HALT;
                     r_halted <= 1'b1;
                  end else begin
                     r_pc <= w_redirTarget;
                     if (r_redirectCount != c_cntMax)
                        r_redirectCount <= r_redirectCount + c_cntOne;
                  end
               end else if (!Stall) begin
                  r_pc        <= w_pcPlus4;
                  r_ifIdPc4   <= w_pcPlus4;
                  r_ifIdInst  <= Instruction;
                  r_ifIdValid <= 1'b1;
                  if (r_fetchCount != c_cntMax)
                     r_fetchCount <= r_fetchCount + c_cntOne;
               end
            end
            S_HALT: begin
               r_ifIdPc4   <= '0;
               r_ifIdInst  <= '0;
               r_ifIdValid <= 1'b0;
            end
            default: begin
               r_state  <= S_HALT;
               r_halted <= 1'b1;
            end
         endcase
      end
   end

   assign FlushIDEX         = Redirect & ~reset & (r_state == S_RUN);
   assign PC                = r_pc;
   assign IF_ID_PC_4        = r_ifIdPc4;
   assign IF_ID_Instruction = r_ifIdInst;
   assign IF_ID_Valid       = r_ifIdValid;
   assign AddrError         = r_addrError;
   assign Halted            = r_halted;
   assign FetchCount        = r_fetchCount;
   assign RedirectCount     = r_redirectCount;

endmodule
`default_nettype wire

// File: tb/tb_if_redirect_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_if_redirect_unit: three configurations driven in lockstep against  |
// | a behavioural fetch model.                         Revision: 1.0      |
// +----------------------------------------------------------------------+
module tb_if_redirect_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] RedirectPC;
   logic [31:0] Instruction;

   logic [31:0] pcO   [3];
   logic [31:0] pc4O  [3];
   logic [31:0] instO [3];
   logic        validO[3];
   logic        flushO[3];
   logic        errO  [3];
   logic        haltO [3];
   logic [15:0] fcA, fcB, rcA, rcB;
   logic [3:0]  fcC, rcC;

   int nChecks = 0;
   int nFails  = 0;

   // Per-instance configuration: A = defaults, B = no halt, C = 4-bit counters.
   bit          cfgHalt[3]   = '{1'b1, 1'b0, 1'b1};
   int unsigned cfgCntMax[3] = '{65535, 65535, 15};

   // Reference state.
   logic [31:0] mPc[3], mPc4[3], mInst[3];
   bit          mValid[3], mErr[3], mHalt[3];
   int unsigned mFc[3], mRc[3];

   always #5 clk = ~clk;

   if_redirect_unit dutA (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .Instruction(Instruction),
      .PC(pcO[0]), .IF_ID_PC_4(pc4O[0]), .IF_ID_Instruction(instO[0]),
      .IF_ID_Valid(validO[0]), .FlushIDEX(flushO[0]), .AddrError(errO[0]),
      .Halted(haltO[0]), .FetchCount(fcA), .RedirectCount(rcA));

   if_redirect_unit #(.HaltOnMisalign(1'b0)) dutB (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .Instruction(Instruction),
      .PC(pcO[1]), .IF_ID_PC_4(pc4O[1]), .IF_ID_Instruction(instO[1]),
      .IF_ID_Valid(validO[1]), .FlushIDEX(flushO[1]), .AddrError(errO[1]),
      .Halted(haltO[1]), .FetchCount(fcB), .RedirectCount(rcB));

   if_redirect_unit #(.CntBits(4)) dutC (
      .clk(clk), .reset(reset), .Stall(Stall), .Redirect(Redirect),
      .RedirectPC(RedirectPC), .Instruction(Instruction),
      .PC(pcO[2]), .IF_ID_PC_4(pc4O[2]), .IF_ID_Instruction(instO[2]),
      .IF_ID_Valid(validO[2]), .FlushIDEX(flushO[2]), .AddrError(errO[2]),
      .Halted(haltO[2]), .FetchCount(fcC), .RedirectCount(rcC));

   task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fetchCnt(input int i);
      case (i)
         0:       return {16'h0, fcA};
         1:       return {16'h0, fcB};
         default: return {28'h0, fcC};
      endcase
   endfunction

   function automatic logic [31:0] redirCnt(input int i);
      case (i)
         0:       return {16'h0, rcA};
         1:       return {16'h0, rcB};
         default: return {28'h0, rcC};
      endcase
   endfunction

   // One clock edge of the architectural fetch behaviour.
   task automatic modelEdge(input int i, input bit rs, input bit rd, input bit st,
                            input logic [31:0] rpc, input logic [31:0] inst);
      bit mis;
      mis = (rpc % 4) != 0;
      if (rs) begin
         mPc[i] = 32'h0040_0000; mPc4[i] = 0; mInst[i] = 0; mValid[i] = 0;
         mErr[i] = 0; mHalt[i] = 0; mFc[i] = 0; mRc[i] = 0;
      end else if (mHalt[i]) begin
         mPc4[i] = 0; mInst[i] = 0; mValid[i] = 0;
      end else if (rd) begin
         mPc4[i] = 0; mInst[i] = 0; mValid[i] = 0;
         if (mis) mErr[i] = 1;
         if (mis && cfgHalt[i]) mHalt[i] = 1;
         else begin
            mPc[i] = rpc - (rpc % 4);
            if (mRc[i] < cfgCntMax[i]) mRc[i]++;
         end
      end else if (!st) begin
         mPc[i]   = mPc[i] + 32'd4;
         mPc4[i]  = mPc[i];
         mInst[i] = inst;
         mValid[i] = 1;
         if (mFc[i] < cfgCntMax[i]) mFc[i]++;
      end
   endtask

   task automatic checkDut(input int i);
      checkEq($sformatf("pc[%0d]", i),    pcO[i],          mPc[i]);
      checkEq($sformatf("pc4[%0d]", i),   pc4O[i],         mPc4[i]);
      checkEq($sformatf("inst[%0d]", i),  instO[i],        mInst[i]);
      checkEq($sformatf("valid[%0d]", i), {31'h0, validO[i]}, {31'h0, mValid[i]});
      checkEq($sformatf("err[%0d]", i),   {31'h0, errO[i]},   {31'h0, mErr[i]});
      checkEq($sformatf("halt[%0d]", i),  {31'h0, haltO[i]},  {31'h0, mHalt[i]});
      checkEq($sformatf("fcnt[%0d]", i),  fetchCnt(i),     mFc[i]);
      checkEq($sformatf("rcnt[%0d]", i),  redirCnt(i),     mRc[i]);
   endtask

   task automatic step(input bit rs, input bit rd, input bit st,
                       input logic [31:0] rpc, input logic [31:0] inst);
      reset = rs; Redirect = rd; Stall = st; RedirectPC = rpc; Instruction = inst;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         checkEq($sformatf("flush[%0d]", i), {31'h0, flushO[i]},
                 {31'h0, rd & ~rs & ~mHalt[i]});
      @(posedge clk);
      for (int i = 0; i < 3; i++) modelEdge(i, rs, rd, st, rpc, inst);
      #1;
      for (int i = 0; i < 3; i++) checkDut(i);
   endtask

   initial begin
      logic [31:0] rpc;
      bit rd, st, rs;
      reset = 1'b1; Redirect = 1'b0; Stall = 1'b0; RedirectPC = '0; Instruction = '0;
      for (int i = 0; i < 3; i++) begin
         mPc[i] = 0; mPc4[i] = 0; mInst[i] = 0; mValid[i] = 0;
         mErr[i] = 0; mHalt[i] = 0; mFc[i] = 0; mRc[i] = 0;
      end
      @(posedge clk); #1;

      step(1, 0, 0, 32'h0, 32'h0);
      checkEq("rst_pc", pcO[0], 32'h0040_0000);
      step(0, 0, 0, 32'h0, 32'h2008_0005);
      checkEq("pc4_first", pc4O[0], 32'h0040_0004);
      step(0, 0, 0, 32'h0, 32'h2008_0005);
      step(0, 0, 0, 32'h0, 32'h2008_0005);
      checkEq("pc_after3", pcO[0], 32'h0040_000C);
      checkEq("fcnt_after3", {16'h0, fcA}, 32'd3);

      step(0, 0, 1, 32'h0, 32'hDEAD_BEEF);
      step(0, 0, 1, 32'h0, 32'hDEAD_BEEF);
      checkEq("stall_pc", pcO[0], 32'h0040_000C);

      step(0, 1, 1, 32'h0040_0040, 32'h1111_1111);
      checkEq("redir_pc", pcO[0], 32'h0040_0040);
      checkEq("redir_cnt", {16'h0, rcA}, 32'd1);
      step(0, 0, 0, 32'h0, 32'h2222_2222);
      checkEq("target_pc4", pc4O[0], 32'h0040_0044);

      step(0, 1, 0, 32'h0040_0042, 32'h0);
      checkEq("mis_halt", {31'h0, haltO[0]}, 32'd1);
      checkEq("mis_nohalt_pc", pcO[1], 32'h0040_0040);
      step(0, 1, 0, 32'h0040_0080, 32'h0);
      checkEq("halt_ignores", pcO[0], 32'h0040_0044);
      step(0, 0, 0, 32'h0, 32'h3333_3333);
      step(1, 0, 0, 32'h0, 32'h0);
      checkEq("rst_err", {31'h0, errO[0]}, 32'd0);

      step(0, 1, 0, 32'hFFFF_FFFC, 32'h0);
      step(0, 0, 0, 32'h0, 32'h4444_4444);
      checkEq("wrap_pc", pcO[0], 32'h0);
      checkEq("wrap_pc4", pc4O[0], 32'h0);

      step(1, 0, 0, 32'h0, 32'h0);
      for (int k = 0; k < 20; k++) step(0, 0, 0, 32'h0, $urandom);
      checkEq("sat_fcnt", {28'h0, fcC}, 32'hF);

      for (int k = 0; k < 400; k++) begin
         rs  = ($urandom_range(0, 99) < 2);
         rd  = ($urandom_range(0, 99) < 15);
         st  = ($urandom_range(0, 99) < 30);
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         step(rs, rd, st, rpc, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
`default_nettype wire
